// File: rtl/room_pkg.sv
// Shared types and widths for the room thermal model.
package room_pkg;

  typedef enum logic [1:0] {
    DRIFT = 2'd0,
    HEAT  = 2'd1,
    COOL  = 2'd2,
    FAULT = 2'd3
  } mode_t;

  localparam int TEMP_W = 5;
  localparam logic [TEMP_W-1:0] TEMP_MAX = 5'd31;
  localparam int CNT_W = 8;

  // Mode requested by the current heating/cooling commands.
  function automatic mode_t decode_mode(input logic heat, input logic cool);
    mode_t m;
    case ({heat, cool})
      2'b10:   m = HEAT;
      2'b01:   m = COOL;
      2'b11:   m = FAULT;
      default: m = DRIFT;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/room_model_step_timer.sv
// Step timer: counts cycles since the last clear and ticks once every div cycles.
module step_timer
  import room_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic [CNT_W:0] div,
  output logic           tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] term;

  // div ranges 1..256, so div-1 always fits the 8-bit counter.
  assign term = CNT_W'(div - (CNT_W+1)'(1));
  assign tick = ~clear & (cnt_q == term);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/room_model.sv
// Closed-loop room thermal model: ramps temperature under heat/cool commands
// and drifts toward ambient when idle.
module room_model
  import room_pkg::*;
#(
  parameter int AMBIENT   = 20,
  parameter int INIT_TEMP = 18,
  parameter int HEAT_DIV  = 4,
  parameter int COOL_DIV  = 4,
  parameter int DRIFT_DIV = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              heating,
  input  logic              cooling,
  output logic [TEMP_W-1:0] temperature,
  output logic              changed,
  output logic              conflict
);

  localparam logic [TEMP_W-1:0] AMB_T  = TEMP_W'(AMBIENT);
  localparam logic [TEMP_W-1:0] INIT_T = TEMP_W'(INIT_TEMP);

  mode_t             mode_q;
  mode_t             mode_d;
  logic [TEMP_W-1:0] temp_q;
  logic [TEMP_W-1:0] temp_d;
  logic              changed_q;
  logic              changed_d;
  logic [CNT_W:0]    div_sel;
  logic              clear;
  logic              tick;

  assign mode_d = decode_mode(heating, cooling);

  // Any mode change discards the partial count; FAULT keeps the timer parked.
  assign clear = (mode_d != mode_q) || (mode_q == FAULT);

  always_comb begin
    div_sel = (CNT_W+1)'(1);
    case (mode_q)
      HEAT:    div_sel = (CNT_W+1)'(HEAT_DIV);
      COOL:    div_sel = (CNT_W+1)'(COOL_DIV);
      DRIFT:   div_sel = (CNT_W+1)'(DRIFT_DIV);
      default: div_sel = (CNT_W+1)'(1);
    endcase
  end

  step_timer u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .div  (div_sel),
    .tick (tick)
  );

  // Saturation is tested before the add/subtract so the value never wraps.
  always_comb begin
    temp_d = temp_q;
    if (tick) begin
      case (mode_q)
        HEAT:  if (temp_q != TEMP_MAX) temp_d = temp_q + 1'b1;
        COOL:  if (temp_q != '0)       temp_d = temp_q - 1'b1;
        DRIFT: begin
          if (temp_q > AMB_T)      temp_d = temp_q - 1'b1;
          else if (temp_q < AMB_T) temp_d = temp_q + 1'b1;
        end
        default: temp_d = temp_q;
      endcase
    end
  end

  assign changed_d = (temp_d != temp_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= DRIFT;
      temp_q    <= INIT_T;
      changed_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      temp_q    <= temp_d;
      changed_q <= changed_d;
    end
  end

  assign temperature = temp_q;
  assign changed     = changed_q;
  assign conflict    = (mode_q == FAULT);

endmodule

// File: tb/tb_room_model.sv
// Bench for room_model: behavioural model compared every cycle, directed
// literal checks, random stimulus and a simple thermostat closed loop.
module tb_room_model;

  logic       clk;
  logic       rst;
  logic       heating;
  logic       cooling;
  logic [4:0] temperature;
  logic       changed;
  logic       conflict;

  int checks;
  int errors;
  bit chk_en;

  // Behavioural model: mode as 0 idle, 1 heat, 2 cool, 3 both; age = edges since entry.
  int m_temp;
  int m_mode;
  int m_age;
  bit m_chg;

  room_model dut (
    .clk        (clk),
    .rst        (rst),
    .heating    (heating),
    .cooling    (cooling),
    .temperature(temperature),
    .changed    (changed),
    .conflict   (conflict)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int req_mode(input logic h, input logic c);
    if (h && c) return 3;
    if (h)      return 1;
    if (c)      return 2;
    return 0;
  endfunction

  function automatic int period(input int md);
    if (md == 1) return 4;
    if (md == 2) return 4;
    return 16;
  endfunction

  always @(posedge clk) begin
    int nm;
    int nt;
    if (rst) begin
      m_temp = 18;
      m_mode = 0;
      m_age  = 0;
      m_chg  = 1'b0;
    end else begin
      nm = req_mode(heating, cooling);
      if (nm != m_mode) begin
        m_mode = nm;
        m_age  = 0;
        m_chg  = 1'b0;
      end else begin
        m_age = m_age + 1;
        nt = m_temp;
        if (m_mode != 3 && (m_age % period(m_mode)) == 0) begin
          if (m_mode == 1)      nt = (m_temp < 31) ? m_temp + 1 : 31;
          else if (m_mode == 2) nt = (m_temp > 0) ? m_temp - 1 : 0;
          else if (m_temp > 20) nt = m_temp - 1;
          else if (m_temp < 20) nt = m_temp + 1;
        end
        m_chg  = (nt != m_temp);
        m_temp = nt;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_temp", int'(temperature), m_temp);
      chk("model_changed", int'(changed), int'(m_chg));
      chk("model_conflict", int'(conflict), (m_mode == 3) ? 1 : 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic h, input logic c);
    heating = h;
    cooling = c;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    chk_en  = 1'b0;
    rst     = 1'b1;
    heating = 1'b0;
    cooling = 1'b0;
    cyc(2);
    chk("reset_temp", int'(temperature), 18);
    chk("reset_changed", int'(changed), 0);
    chk("reset_conflict", int'(conflict), 0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Heat ramp 18 -> 31, first step on E+4, saturation at E+52.
    drive(1'b1, 1'b0);
    cyc(4);
    chk("heat_before_E4", int'(temperature), 18);
    cyc(1);
    chk("heat_E4", int'(temperature), 19);
    chk("heat_E4_changed", int'(changed), 1);
    cyc(48);
    chk("heat_E52", int'(temperature), 31);
    cyc(20);
    chk("heat_hold31", int'(temperature), 31);

    // Cool ramp 31 -> 0 (31 steps of 4 edges), then hold.
    drive(1'b0, 1'b1);
    cyc(125);
    chk("cool_E124", int'(temperature), 0);
    cyc(20);
    chk("cool_hold0", int'(temperature), 0);
    chk("cool_hold0_changed", int'(changed), 0);

    // Heat 0 -> 25 then conflict and recovery.
    drive(1'b1, 1'b0);
    cyc(101);
    chk("heat_to25", int'(temperature), 25);
    drive(1'b1, 1'b1);
    cyc(1);
    chk("conflict_rise", int'(conflict), 1);
    cyc(9);
    chk("conflict_frozen", int'(temperature), 25);
    drive(1'b1, 1'b0);
    cyc(4);
    chk("recover_E3", int'(temperature), 25);
    cyc(1);
    chk("recover_E4", int'(temperature), 26);
    chk("recover_conflict", int'(conflict), 0);

    // Drift down 26 -> 20 over 6 steps of 16 edges.
    drive(1'b0, 1'b0);
    cyc(16);
    chk("drift_E15", int'(temperature), 26);
    cyc(1);
    chk("drift_E16", int'(temperature), 25);
    cyc(80);
    chk("drift_E96", int'(temperature), 20);
    cyc(40);
    chk("drift_hold20", int'(temperature), 20);

    // Heat to 27 and reset mid-ramp.
    drive(1'b1, 1'b0);
    cyc(29);
    chk("heat_to27", int'(temperature), 27);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    chk("midramp_reset", int'(temperature), 18);
    chk("midramp_reset_changed", int'(changed), 0);
    rst = 1'b0;

    // Cool 18 -> 15, then drift upward to 20.
    drive(1'b0, 1'b1);
    cyc(13);
    chk("cool_to15", int'(temperature), 15);
    drive(1'b0, 1'b0);
    cyc(81);
    chk("drift_up20", int'(temperature), 20);

    // Randomized commands with variable hold lengths and rare resets.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      rst = ($urandom_range(0, 40) == 0);
      cyc(1);
      rst = 1'b0;
      cyc($urandom_range(0, 24));
    end

    // Closed loop against a simple hysteresis thermostat.
    rst = 1'b1;
    drive(1'b0, 1'b0);
    cyc(1);
    rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      drive(temperature < 5'd19, temperature > 5'd21);
      cyc(1);
      if (i >= 50) begin
        checks++;
        if (temperature < 5'd18 || temperature > 5'd22 || conflict) begin
          errors++;
          $display("FAIL loop_range: got temp %0d conflict %0d expected 18..22 and 0",
                   temperature, conflict);
        end
      end
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
